master_port: RTL

Bus-master serial port: the initiator-side counterpart of the slave port on the system bus. It accepts a read or write request (12-bit address, 4-bit burst length) from local master logic. It serialises address, burst and write data to the slave over single-bit lines, and deserialises read data returned by the slave. One instance sits between each bus master's control logic and the bus interconnect.

---
 rtl/master_port_if.sv | 40 ++++
 rtl/master_port.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/master_port_if.sv
// Serial bus between a bus-master port and its slave port.
// The master modport drives enables and tx lines; the slave modport returns handshakes and rx data.
interface master_port_if;
    logic read_en;
    logic write_en;
    logic master_valid;
    logic master_ready;
    logic slave_ready;
    logic slave_valid;
    logic tx_addr;
    logic tx_burst;
    logic tx_data;
    logic rx_data;

    modport master (
        output read_en,
        output write_en,
        output master_valid,
        output master_ready,
        output tx_addr,
        output tx_burst,
        output tx_data,
        input  slave_ready,
        input  slave_valid,
        input  rx_data
    );

    modport slave (
        input  read_en,
        input  write_en,
        input  master_valid,
        input  master_ready,
        input  tx_addr,
        input  tx_burst,
        input  tx_data,
        output slave_ready,
        output slave_valid,
        output rx_data
    );
endinterface

// File: rtl/master_port.sv
// Bus-master serial port: serialises address, burst and write beats LSB first and
// deserialises read beats from the slave.
module master_port #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned BURST_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [BURST_WIDTH-1:0] req_burst,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   rd_valid,
    output logic                   done,
    master_port_if.master          bus
);

    localparam int unsigned CntW = $clog2(ADDR_WIDTH);
    localparam logic [CntW-1:0] AddrLast = CntW'(ADDR_WIDTH - 1);
    localparam logic [CntW-1:0] DataLast = CntW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {StIdle, StAddr, StWload, StWdata, StRdata, StDone} state_e;

    state_e                 state_q, state_d;
    logic                   write_q;
    logic [ADDR_WIDTH-1:0]  addr_sh_q;
    logic [BURST_WIDTH-1:0] burst_sh_q;
    logic [DATA_WIDTH-1:0]  data_sh_q;
    logic [DATA_WIDTH-1:0]  rd_data_q;
    logic                   rd_valid_q;
    logic [CntW-1:0]        bit_cnt_q;
    logic [BURST_WIDTH-1:0] beat_cnt_q;

    logic                  addr_last;
    logic                  data_last;
    logic                  beat_zero;
    logic [DATA_WIDTH-1:0] rx_shift;

    assign addr_last = (bit_cnt_q == AddrLast);
    assign data_last = (bit_cnt_q == DataLast);
    assign beat_zero = (beat_cnt_q == '0);
    assign rx_shift  = {bus.rx_data, data_sh_q[DATA_WIDTH-1:1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (req_valid) state_d = StAddr;
            StAddr:  if (bus.slave_ready && addr_last) state_d = write_q ? StWload : StRdata;
            StWload: if (wr_valid) state_d = StWdata;
            StWdata: if (bus.slave_ready && data_last) state_d = beat_zero ? StDone : StWload;
            StRdata: if (bus.slave_valid && data_last && beat_zero) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            write_q    <= 1'b0;
            addr_sh_q  <= '0;
            burst_sh_q <= '0;
            data_sh_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            bit_cnt_q  <= '0;
            beat_cnt_q <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        write_q    <= req_write;
                        addr_sh_q  <= req_addr;
                        burst_sh_q <= req_burst;
                        beat_cnt_q <= req_burst;
                        bit_cnt_q  <= '0;
                    end
                end
                StAddr: begin
                    // Burst bits ride alongside the first address bits, then zeros shift out.
                    if (bus.slave_ready) begin
                        addr_sh_q  <= addr_sh_q >> 1;
                        burst_sh_q <= burst_sh_q >> 1;
                        bit_cnt_q  <= addr_last ? '0 : bit_cnt_q + 1'b1;
                    end
                end
                StWload: begin
                    if (wr_valid) data_sh_q <= wr_data;
                end
                StWdata: begin
                    if (bus.slave_ready) begin
                        data_sh_q <= data_sh_q >> 1;
                        if (data_last) begin
                            bit_cnt_q <= '0;
                            if (!beat_zero) beat_cnt_q <= beat_cnt_q - 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                StRdata: begin
                    if (bus.slave_valid) begin
                        data_sh_q <= rx_shift;
                        if (data_last) begin
                            rd_data_q  <= rx_shift;
                            rd_valid_q <= 1'b1;
                            bit_cnt_q  <= '0;
                            if (!beat_zero) beat_cnt_q <= beat_cnt_q - 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready        = 1'b0;
        wr_ready         = 1'b0;
        done             = 1'b0;
        bus.read_en      = 1'b0;
        bus.write_en     = 1'b0;
        bus.master_valid = 1'b0;
        bus.master_ready = 1'b0;
        bus.tx_addr      = 1'b0;
        bus.tx_burst     = 1'b0;
        bus.tx_data      = 1'b0;
        rd_data          = rd_data_q;
        rd_valid         = rd_valid_q;
        case (state_q)
            StIdle: req_ready = 1'b1;
            StAddr: begin
                bus.read_en      = !write_q;
                bus.write_en     = write_q;
                bus.master_valid = 1'b1;
                bus.tx_addr      = addr_sh_q[0];
                bus.tx_burst     = burst_sh_q[0];
            end
            StWload: begin
                bus.write_en = 1'b1;
                wr_ready     = 1'b1;
            end
            StWdata: begin
                bus.write_en     = 1'b1;
                bus.master_valid = 1'b1;
                bus.tx_data      = data_sh_q[0];
            end
            StRdata: begin
                bus.read_en      = 1'b1;
                bus.master_ready = 1'b1;
            end
            StDone: done = 1'b1;
            default: ;
        endcase
    end

endmodule
